// File: rtl/act_word_serializer_pkg.sv
// act_word_serializer_pkg: shared widths and FSM encoding for the activation word serializer
package act_word_serializer_pkg;
    localparam int ACT_WIDTH = 8;
    localparam int CNT_WIDTH_DEF = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/act_word_serializer.sv
// act_word_serializer: splits wide activation words into LSB-first slices, one per cycle
module act_word_serializer
    import act_word_serializer_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = ACT_WIDTH,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_val,
    output logic                 cfg_rdy,
    input  logic [CNT_WIDTH-1:0] cfg_word_num,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int NUM_SLICE = IN_WIDTH / OUT_WIDTH;
    localparam int SW = $clog2(NUM_SLICE);
    localparam logic [SW-1:0] LAST_SLICE = SW'(NUM_SLICE - 1);

    state_t state, state_n;
    logic [IN_WIDTH-1:0]  hold_q;
    logic                 hold_full;
    logic [SW-1:0]        slice_idx;
    logic [CNT_WIDTH-1:0] word_num, words_loaded;
    logic                 zero_done;
    logic                 last_slice, cfg_go, xfer, load;

    always_comb begin
        last_slice = slice_idx == LAST_SLICE;
        cfg_rdy    = state == IDLE;
        busy       = state != IDLE;
        cfg_go     = cfg_val & cfg_rdy;
        out_val    = hold_full & !reset;
        // reload is allowed while the final slice of the held word leaves
        in_rdy     = !reset & (state == RUN) & (words_loaded < word_num) &
                     (!hold_full | (last_slice & out_rdy));
        xfer       = out_val & out_rdy;
        load       = in_val & in_rdy;
        out_data   = hold_q[slice_idx*OUT_WIDTH +: OUT_WIDTH];
        out_last   = out_val & last_slice & (words_loaded == word_num);
        done       = (state == DONE) | zero_done;
        state_n    = state == IDLE ? ((cfg_go && cfg_word_num != '0) ? RUN : IDLE) :
                     state == RUN  ? ((xfer && out_last) ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_q       <= '0;
            hold_full    <= 1'b0;
            slice_idx    <= '0;
            word_num     <= '0;
            words_loaded <= '0;
            zero_done    <= 1'b0;
        end else begin
            state     <= state_n;
            zero_done <= cfg_go && cfg_word_num == '0;
            if (cfg_go) begin
                word_num     <= cfg_word_num;
                words_loaded <= '0;
            end
            if (load) begin
                hold_q       <= in_data;
                hold_full    <= 1'b1;
                slice_idx    <= '0;
                words_loaded <= words_loaded + 1'b1;
            end else if (xfer) begin
                slice_idx <= last_slice ? '0 : slice_idx + 1'b1;
                hold_full <= !last_slice;
            end
        end
    end
endmodule

// File: tb/tb_act_word_serializer.sv
// tb_act_word_serializer: scoreboard bench driving framed words and checking slice order, last and done
module tb_act_word_serializer;
    localparam int IW = 64;
    localparam int OW = 8;
    localparam int CW = 16;
    localparam int NS = IW / OW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_val, cfg_rdy;
    logic [CW-1:0] cfg_word_num;
    logic          in_val, in_rdy;
    logic [IW-1:0] in_data;
    logic          out_val, out_rdy;
    logic [OW-1:0] out_data;
    logic          out_last, busy, done;

    always #5 clk = ~clk;

    act_word_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_word_num(cfg_word_num),
        .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    int errors = 0;
    int checks = 0;
    logic [OW:0]   sb[$];
    logic [IW-1:0] src_q[$];
    int gap_cnt, gap, words_taken;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        in_val  = src_q.size() > 0 && gap_cnt == 0;
        in_data = src_q.size() > 0 ? src_q[0] : '0;
    endtask

    task automatic run_frame(input int n, input int gp, input bit toggle, input int exp_span,
                             input int abort_at, input int poke_at);
        int xfers, first_k, last_k;
        bit seen_done;
        logic [IW-1:0] w;
        logic lf;
        gap = gp; gap_cnt = 0; words_taken = 0; xfers = 0;
        first_k = -1; last_k = -1; seen_done = 0;
        cfg_val = 1'b1; cfg_word_num = CW'(n); out_rdy = !toggle;
        drive_src();
        @(negedge clk);
        check("cfg_rdy_idle", cfg_rdy, 1);
        @(posedge clk); #1;
        for (int k = 1; k < 200 && !seen_done; k++) begin
            out_rdy = toggle ? (k % 2 == 1) : 1'b1;
            cfg_val = (k == poke_at);
            cfg_word_num = cfg_val ? CW'(5) : CW'(n);
            drive_src();
            @(negedge clk);
            if (cfg_val) check("cfg_rdy_run", cfg_rdy, 0);
            if (abort_at >= 0 && xfers == abort_at && out_val) begin
                check("abort_slice", out_data, sb[0][OW-1:0]);
                reset = 1'b1; #1;
                check("rst_out_val", out_val, 0);
                check("rst_in_rdy", in_rdy, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                src_q.delete(); sb.delete(); drive_src();
                @(negedge clk);
                check("post_rst_out_val", out_val, 0);
                check("post_rst_in_rdy", in_rdy, 0);
                check("post_rst_cfg_rdy", cfg_rdy, 1);
                check("post_rst_busy", busy, 0);
                @(posedge clk); #1;
                return;
            end
            if (out_val) begin
                if (sb.size() == 0) check("spurious_val", out_val, 0);
                else begin
                    check("out_data", out_data, sb[0][OW-1:0]);
                    check("out_last", out_last, sb[0][OW]);
                    if (out_rdy) begin
                        void'(sb.pop_front());
                        xfers++;
                        last_k = k;
                    end
                end
                if (first_k < 0) first_k = k;
            end else check("last_idle", out_last, 0);
            if (in_val && in_rdy) begin
                words_taken++;
                w = src_q[0];
                for (int s = 0; s < NS; s++) begin
                    lf = (s == NS - 1) && (words_taken == n);
                    sb.push_back({lf, w[s*OW +: OW]});
                end
                void'(src_q.pop_front());
                gap_cnt = gap;
            end else if (gap_cnt > 0) gap_cnt--;
            if (done) begin
                seen_done = 1;
                check("done_timing", k - last_k, 1);
                check("done_busy", busy, 1);
            end
            @(posedge clk); #1;
        end
        cfg_val = 1'b0;
        check("done_seen", seen_done, 1);
        check("sb_drained", sb.size(), 0);
        check("words_taken", words_taken, n);
        if (exp_span > 0) check("span", last_k - first_k + 1, exp_span);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_src();
            @(negedge clk);
            check("after_done", done, 0);
            check("after_cfg_rdy", cfg_rdy, 1);
            check("after_busy", busy, 0);
            check("after_in_rdy", in_rdy, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; cfg_val = 1'b0; cfg_word_num = '0;
        in_val = 1'b0; in_data = '0; out_rdy = 1'b1; gap_cnt = 0;
        @(negedge clk);
        check("rst_in_rdy0", in_rdy, 0);
        check("rst_out_val0", out_val, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("init_cfg_rdy", cfg_rdy, 1);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_out_last", out_last, 0);
        check("init_out_data", out_data, 0);
        @(posedge clk); #1;

        src_q = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
        run_frame(2, 0, 0, 16, -1, -1);

        src_q = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
        run_frame(2, 0, 1, 32, -1, -1);

        src_q = '{64'hA7A6A5A4A3A2A1A0, 64'hB7B6B5B4B3B2B1B0, 64'hC7C6C5C4C3C2C1C0, 64'hD7D6D5D4D3D2D1D0};
        run_frame(3, 3, 0, 0, -1, -1);
        check("fourth_unpopped", src_q.size(), 1);
        src_q.delete();

        src_q = '{64'hDEADBEEFCAFEF00D};
        gap_cnt = 0; drive_src();
        cfg_val = 1'b1; cfg_word_num = '0;
        @(negedge clk);
        check("z_cfg_rdy", cfg_rdy, 1);
        check("z_in_rdy0", in_rdy, 0);
        check("z_done0", done, 0);
        @(posedge clk); #1;
        cfg_val = 1'b0;
        @(negedge clk);
        check("z_done1", done, 1);
        check("z_busy1", busy, 0);
        check("z_in_rdy1", in_rdy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("z_done2", done, 0);
        check("z_busy2", busy, 0);
        check("z_in_rdy2", in_rdy, 0);
        @(posedge clk); #1;
        src_q.delete(); drive_src();

        src_q = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
        run_frame(2, 0, 0, 16, 3, -1);

        src_q = '{64'h1122334455667788};
        run_frame(1, 0, 0, 8, -1, -1);

        src_q = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
        run_frame(2, 0, 0, 16, -1, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/act_word_serializer.md
Name: act_word_serializer

Overview:
- Sits directly downstream of the activation FIFO stage, on its PEB-side read port.
- Accepts wide activation words over a valid/ready handshake and emits them one activation slice per cycle toward the PE array.
- A frame is configured as a fixed number of words. The final slice of the final word is tagged with out_last, and completion is reported with a one-cycle done pulse.

Parameters:
- IN_WIDTH, 64, width of one input word; instantiations pass `REGACT_WR_WIDTH`. Must be a multiple of OUT_WIDTH.
- OUT_WIDTH, 8, width of one activation slice.
- CNT_WIDTH, 16, width of the frame word counter.
- NUM_SLICE (localparam) = IN_WIDTH/OUT_WIDTH; must be >= 2.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- cfg_val  in  1  frame configuration valid.
- cfg_rdy  out  1  high only in IDLE.
- cfg_word_num  in  CNT_WIDTH  number of input words in the frame.
- in_val  in  1  input word valid (upstream dataout_val).
- in_rdy  out  1  input word ready (upstream dataout_rdy).
- in_data  in  IN_WIDTH  input word.
- out_val  out  1  slice valid.
- out_rdy  in  1  downstream accepts the slice.
- out_data  out  OUT_WIDTH  current slice.
- out_last  out  1  high with the final slice of the frame.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (synchronous, active-high):
  - While reset is high, in_rdy and out_val are forced 0.
  - On the clock edge with reset high: state goes to IDLE; the hold buffer, slice index and word counter clear.
  - Output values out of reset: cfg_rdy=1, busy=0, done=0, out_last=0, out_data=0.
- Reset mid-frame: any buffered word is discarded and no out_last is produced. The first frame after reset starts at slice 0.
- States:
  - IDLE: cfg_rdy=1.
    - cfg_val & cfg_rdy with cfg_word_num=0: stay in IDLE, assert done next cycle.
    - cfg_val & cfg_rdy with cfg_word_num>0: latch word_num, go to RUN.
  - RUN: cfg_val is ignored.
    - The transfer of slice NUM_SLICE-1 of word word_num-1 (the last slice) moves the block to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
- in_rdy:
  - in_rdy = RUN & (words_loaded < word_num) & (!buf_full | (slice_idx==NUM_SLICE-1 & out_rdy)).
  - in_rdy must not depend combinationally on in_val; the upstream valid is itself a function of its ready.
- Words beyond word_num are never consumed.
- Zero-bubble reload: a new word may be loaded in the same cycle the last slice of the previous word transfers. Sustained throughput is 1 slice/cycle.
- Slice order is LSB first: slice k = buf[k*OUT_WIDTH +: OUT_WIDTH].
- Latency: out_val is asserted the cycle after the word handshake.
- Output stability: out_data and out_last must remain stable while out_val & !out_rdy. out_val may drop only after a transfer.
- Counter widths: slice_idx is $clog2(NUM_SLICE) bits and wraps to 0 after slice NUM_SLICE-1. words_loaded is CNT_WIDTH bits and saturates at word_num.
- out_last = out_val & buffered word is word word_num-1 & slice_idx==NUM_SLICE-1.
- Simultaneous events:
  - Last-slice transfer in the same cycle as a new word load: the buffer is replaced and slice_idx resets to 0.
  - cfg_val during RUN or DONE has no effect.

Decomposition:
- Shared package holds:
  - ACT_WIDTH (=OUT_WIDTH) constant.
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - A CNT_WIDTH default shared with the configuration block.
- Single module; no sub-module needed. Slice select is an indexed part-select; counters are inline.

Test Plan:
- Defaults, cfg_word_num=2, words 0x0706050403020100 then 0x0F0E0D0C0B0A0908, in_val and out_rdy held 1 -> out_data=0x00..0x0F on 16 consecutive cycles with no bubble; out_last only on 0x0F; done=1 the following cycle; then cfg_rdy=1.
- Same frame with out_rdy toggling 1,0,1,0 -> every slice appears exactly once, in order; out_data held steady in out_rdy=0 cycles; 32 cycles total from first out_val to last transfer.
- Upstream FIFO-model source with 3-cycle gaps and cfg_word_num=3, four words offered -> out_val low during starvation, order preserved; in_rdy stays 0 after the third word, so the fourth word remains unpopped.
- cfg_word_num=0 -> done=1 exactly one cycle after the cfg handshake; in_rdy never asserted; busy stays 0.
- reset asserted for 1 cycle while slice 3 of word 0 is on the output -> next cycle out_val=0, in_rdy=0, cfg_rdy=1. A new frame with cfg_word_num=1 and word 0x1122334455667788 -> first slice 0x88.
- cfg_val pulsed with cfg_word_num=5 during RUN of a 2-word frame -> ignored; frame ends after 16 slices; done fires once.
